// File: rtl/soc_mon_pkg.sv
// Shared definitions for the run monitor: state encoding and halt defaults.
package soc_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_DONE    = 2'd2,
        ST_TIMEOUT = 2'd3
    } mon_state_t;

    localparam int          HALT_REG_DEF   = 31;
    localparam logic [31:0] HALT_VALUE_DEF = 32'h0000_03FF;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; holds at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_q <= '0;
        end else if (inc && (r_q != {W{1'b1}})) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/soc_run_monitor.sv
// Program run monitor: counts RUN cycles and events until a halt-register write
// or a run-length timeout, then freezes the counters until cleared.
//
// state      | meaning
// -----------|------------------------------------------------------
// ST_IDLE    | counters held at zero, waiting for enable_i
// ST_RUN     | counting cycles/events, watching for halt or timeout
// ST_DONE    | halt write seen, counters frozen until clear_i
// ST_TIMEOUT | run length hit TIMEOUT_CYCLES, frozen until clear_i
module soc_run_monitor
    import soc_mon_pkg::*;
#(
    parameter int          CNT_W          = 32,
    parameter int          NUM_EVT        = 4,
    parameter int          HALT_REG       = HALT_REG_DEF,
    parameter logic [31:0] HALT_VALUE     = HALT_VALUE_DEF,
    parameter int          TIMEOUT_CYCLES = 50000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable_i,
    input  logic                     clear_i,
    input  logic [NUM_EVT-1:0]       evt_i,
    input  logic                     rf_we_i,
    input  logic [4:0]               rf_waddr_i,
    input  logic [31:0]              rf_wdata_i,
    output logic [1:0]               state_o,
    output logic [CNT_W-1:0]         cycle_cnt_o,
    output logic [NUM_EVT*CNT_W-1:0] evt_cnt_o,
    output logic                     done_o,
    output logic                     timeout_o
);

    localparam int         TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [4:0] HALT_IDX = 5'(HALT_REG);

    mon_state_t       r_state;
    mon_state_t       w_state_nxt;
    logic [TMO_W-1:0] r_tmo_left;
    logic             r_done;
    logic             r_timeout;
    logic             w_run;
    logic             w_clr;
    logic             w_halt_hit;
    logic             w_tmo_hit;

    assign w_run = (r_state == ST_RUN);
    assign w_clr = ((r_state == ST_DONE) || (r_state == ST_TIMEOUT)) && clear_i;

    // Index 0 is the hard-wired zero register; a write there is never a halt.
    assign w_halt_hit = w_run && rf_we_i && (rf_waddr_i == HALT_IDX)
                        && (rf_waddr_i != 5'd0) && (rf_wdata_i == HALT_VALUE);

    // Run length is tracked separately so timeout still fires when the
    // visible cycle counter has saturated below TIMEOUT_CYCLES.
    assign w_tmo_hit = w_run && (r_tmo_left == TMO_W'(1));

    always_ff @(posedge clk) begin
        if (rst || (r_state == ST_IDLE)) begin
            r_tmo_left <= TMO_W'(TIMEOUT_CYCLES);
        end else if (w_run && (r_tmo_left != '0)) begin
            r_tmo_left <= r_tmo_left - TMO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_done    <= (w_state_nxt == ST_DONE);
            r_timeout <= (w_state_nxt == ST_TIMEOUT);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (enable_i) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_halt_hit)     w_state_nxt = ST_DONE;
                else if (w_tmo_hit) w_state_nxt = ST_TIMEOUT;
            end
            ST_DONE, ST_TIMEOUT: begin
                if (clear_i) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk (clk),
        .rst (rst),
        .clr (w_clr),
        .inc (w_run),
        .q   (cycle_cnt_o)
    );

    for (genvar k = 0; k < NUM_EVT; k++) begin : g_evt
        sat_counter #(.W(CNT_W)) u_evt_cnt (
            .clk (clk),
            .rst (rst),
            .clr (w_clr),
            .inc (w_run && evt_i[k]),
            .q   (evt_cnt_o[k*CNT_W +: CNT_W])
        );
    end

    assign state_o   = r_state;
    assign done_o    = r_done;
    assign timeout_o = r_timeout;

endmodule

// File: tb/tb_soc_run_monitor.sv
// Directed bench: two monitor instances (32-bit/timeout 20, 4-bit/default
// timeout) share one stimulus stream and are checked against hand values.
module tb_soc_run_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable_i;
    logic        clear_i;
    logic [3:0]  evt_i;
    logic        rf_we_i;
    logic [4:0]  rf_waddr_i;
    logic [31:0] rf_wdata_i;

    logic [1:0]   a_state, b_state;
    logic [31:0]  a_cycle;
    logic [3:0]   b_cycle;
    logic [127:0] a_evt;
    logic [15:0]  b_evt;
    logic         a_done, a_tmo, b_done, b_tmo;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    soc_run_monitor #(.CNT_W(32), .NUM_EVT(4), .TIMEOUT_CYCLES(20)) u_dut_a (
        .clk         (clk),
        .rst         (rst),
        .enable_i    (enable_i),
        .clear_i     (clear_i),
        .evt_i       (evt_i),
        .rf_we_i     (rf_we_i),
        .rf_waddr_i  (rf_waddr_i),
        .rf_wdata_i  (rf_wdata_i),
        .state_o     (a_state),
        .cycle_cnt_o (a_cycle),
        .evt_cnt_o   (a_evt),
        .done_o      (a_done),
        .timeout_o   (a_tmo)
    );

    soc_run_monitor #(.CNT_W(4), .NUM_EVT(4)) u_dut_b (
        .clk         (clk),
        .rst         (rst),
        .enable_i    (enable_i),
        .clear_i     (clear_i),
        .evt_i       (evt_i),
        .rf_we_i     (rf_we_i),
        .rf_waddr_i  (rf_waddr_i),
        .rf_wdata_i  (rf_wdata_i),
        .state_o     (b_state),
        .cycle_cnt_o (b_cycle),
        .evt_cnt_o   (b_evt),
        .done_o      (b_done),
        .timeout_o   (b_tmo)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_inputs();
        enable_i   = 1'b0;
        clear_i    = 1'b0;
        evt_i      = 4'b0000;
        rf_we_i    = 1'b0;
        rf_waddr_i = 5'd0;
        rf_wdata_i = 32'h0;
    endtask

    task automatic rf_write(input logic [4:0] idx, input logic [31:0] data);
        rf_we_i    = 1'b1;
        rf_waddr_i = idx;
        rf_wdata_i = data;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick(3);
        chk("rst_state",   64'(a_state), 64'd0);
        chk("rst_cycle",   64'(a_cycle), 64'd0);
        chk("rst_evt",     64'(a_evt[63:0]) | 64'(a_evt[127:64]), 64'd0);
        chk("rst_flags",   {62'd0, a_done, a_tmo}, 64'd0);
        chk("rst_b_state", 64'(b_state), 64'd0);

        // Run 1: halt on RUN cycle 10, events on the halt cycle counted
        rst = 1'b0;
        evt_i = 4'b1111;
        tick(2);
        chk("idle_evt_ignored", 64'(a_evt[31:0]), 64'd0);
        chk("idle_no_cycles",   64'(a_cycle), 64'd0);
        evt_i = 4'b0000;
        enable_i = 1'b1;
        tick();
        enable_i = 1'b0;
        chk("enter_run",  64'(a_state), 64'd1);
        chk("run_cnt0",   64'(a_cycle), 64'd0);
        tick(9);
        chk("run_cyc9",   64'(a_cycle), 64'd9);
        rf_write(5'd31, 32'h3FF);
        evt_i = 4'b1000;
        tick();
        idle_inputs();
        chk("halt_state", 64'(a_state), 64'd2);
        chk("halt_cycle", 64'(a_cycle), 64'd10);
        chk("halt_done",  {62'd0, a_done, a_tmo}, 64'd2);
        chk("halt_ev3",   64'(a_evt[127:96]), 64'd1);
        evt_i = 4'b1111;
        enable_i = 1'b1;
        tick(3);
        idle_inputs();
        chk("frozen_cycle", 64'(a_cycle), 64'd10);
        chk("frozen_ev0",   64'(a_evt[31:0]), 64'd0);
        chk("done_ign_en",  64'(a_state), 64'd2);
        clear_i = 1'b1;
        tick();
        idle_inputs();
        chk("clr_state", 64'(a_state), 64'd0);
        chk("clr_cycle", 64'(a_cycle), 64'd0);
        chk("clr_ev3",   64'(a_evt[127:96]), 64'd0);
        chk("clr_done",  64'(a_done), 64'd0);

        // Run 2: channel pattern 0101 for 7 cycles, non-hit writes, clear ignored in RUN
        enable_i = 1'b1;
        tick();
        idle_inputs();
        evt_i = 4'b0101;
        clear_i = 1'b1;
        rf_write(5'd0, 32'h3FF);
        tick();
        clear_i = 1'b0;
        rf_write(5'd31, 32'h3FE);
        tick();
        rf_we_i = 1'b0;
        rf_waddr_i = 5'd31;
        rf_wdata_i = 32'h3FF;
        tick(5);
        chk("nohit_state", 64'(a_state), 64'd1);
        chk("nohit_cycle", 64'(a_cycle), 64'd7);
        idle_inputs();
        rf_write(5'd31, 32'h3FF);
        tick();
        idle_inputs();
        chk("r2_state", 64'(a_state), 64'd2);
        chk("r2_cycle", 64'(a_cycle), 64'd8);
        chk("r2_ev0",   64'(a_evt[31:0]),   64'd7);
        chk("r2_ev1",   64'(a_evt[63:32]),  64'd0);
        chk("r2_ev2",   64'(a_evt[95:64]),  64'd7);
        chk("r2_ev3",   64'(a_evt[127:96]), 64'd0);
        chk("r2_b_evt", 64'(b_evt), 64'h0707);
        clear_i = 1'b1;
        tick();
        idle_inputs();

        // Run 3: halt on cycle 20 beats timeout; 4-bit instance saturates
        enable_i = 1'b1;
        tick();
        idle_inputs();
        evt_i = 4'b0001;
        tick(19);
        chk("r3_pre_state", 64'(a_state), 64'd1);
        chk("r3_b_sat",     64'(b_cycle), 64'hF);
        rf_write(5'd31, 32'h3FF);
        tick();
        idle_inputs();
        chk("tie_done",    64'(a_state), 64'd2);
        chk("tie_flags",   {62'd0, a_done, a_tmo}, 64'd2);
        chk("tie_cycle",   64'(a_cycle), 64'd20);
        chk("b_sat_state", 64'(b_state), 64'd2);
        chk("b_sat_cycle", 64'(b_cycle), 64'hF);
        chk("b_sat_ev0",   64'(b_evt[3:0]), 64'hF);
        clear_i = 1'b1;
        tick();
        idle_inputs();

        // Run 4: pure timeout on A, then rst overrides a halt hit mid-RUN on B
        enable_i = 1'b1;
        tick();
        idle_inputs();
        tick(19);
        chk("t_pre_state", 64'(a_state), 64'd1);
        chk("t_pre_flags", {62'd0, a_done, a_tmo}, 64'd0);
        tick();
        chk("tmo_state", 64'(a_state), 64'd3);
        chk("tmo_cycle", 64'(a_cycle), 64'd20);
        chk("tmo_flags", {62'd0, a_done, a_tmo}, 64'd1);
        chk("b_still_run", 64'(b_state), 64'd1);
        tick(2);
        chk("tmo_frozen", 64'(a_cycle), 64'd20);
        clear_i = 1'b1;
        tick();
        idle_inputs();
        chk("tmo_clr_state", 64'(a_state), 64'd0);
        chk("tmo_clr_cycle", 64'(a_cycle), 64'd0);
        chk("tmo_clr_flag",  64'(a_tmo), 64'd0);
        chk("b_clr_ignored", 64'(b_state), 64'd1);
        chk("b_run_sat",     64'(b_cycle), 64'hF);
        rst = 1'b1;
        enable_i = 1'b1;
        clear_i = 1'b1;
        rf_write(5'd31, 32'h3FF);
        tick();
        rst = 1'b0;
        idle_inputs();
        chk("mid_rst_state", 64'(b_state), 64'd0);
        chk("mid_rst_cycle", 64'(b_cycle), 64'd0);
        chk("mid_rst_flags", {62'd0, b_done, b_tmo}, 64'd0);
        chk("mid_rst_a",     64'(a_state), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/soc_run_monitor.md
SOC_RUN_MONITOR -- requirements
Module: soc_run_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of every counter.
REQ-002 SHALL have parameter NUM_EVT, default 4, number of event-count channels (1..16).
REQ-003 SHALL have parameter HALT_REG, default 31, register index whose write signals program completion (1..31).
REQ-004 SHALL have parameter HALT_VALUE, default 32'h000003FF, halt magic value.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 50000, run-length limit in cycles (at least 1).
REQ-006 SHALL have one clock; reset is synchronous and active-high; ports named clk and rst.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 enable_i  input  1  start counting from IDLE.
REQ-010 clear_i  input  1  return from DONE/TIMEOUT to IDLE.
REQ-011 evt_i  input  NUM_EVT  per-channel event strobes, one count per cycle high.
REQ-012 rf_we_i  input  1  register-file write enable snoop.
REQ-013 rf_waddr_i  input  5  register-file write index snoop.
REQ-014 rf_wdata_i  input  32  register-file write data snoop.
REQ-015 state_o  output  2  FSM state (IDLE=0, RUN=1, DONE=2, TIMEOUT=3).
REQ-016 cycle_cnt_o  output  CNT_W  cycles spent in RUN.
REQ-017 evt_cnt_o  output  NUM_EVT*CNT_W  channel k in bits [k*CNT_W +: CNT_W].
REQ-018 done_o  output  1  high while in DONE.
REQ-019 timeout_o  output  1  high while in TIMEOUT.

Function
REQ-020 SHALL leave IDLE for RUN on the first rising edge with enable_i=1; counters stay 0 in IDLE.
REQ-021 SHALL add 1 to cycle_cnt_o on every RUN cycle, so after N RUN cycles it reads N.
REQ-022 SHALL add 1 to channel k on each RUN cycle with evt_i[k]=1; evt_i SHALL be ignored outside RUN.
REQ-023 SHALL saturate every counter at 2^CNT_W-1 with no wrap; TIMEOUT still fires if TIMEOUT_CYCLES exceeds that limit.
REQ-024 A halt hit is rf_we_i=1, rf_waddr_i=HALT_REG and rf_wdata_i=HALT_VALUE in a RUN cycle; a write to index 0 SHALL never count as a hit.
REQ-025 On a halt hit SHALL enter DONE at the next edge; that cycle and its events SHALL be counted.
REQ-026 SHALL enter TIMEOUT at the edge where cycle_cnt_o becomes TIMEOUT_CYCLES, if no halt hit occurs in that cycle.
REQ-027 A halt hit and timeout in the same cycle SHALL resolve to DONE.
REQ-028 Counters SHALL freeze in DONE and TIMEOUT.
REQ-029 clear_i in DONE/TIMEOUT SHALL return to IDLE and zero all counters at the next edge; clear_i SHALL be ignored in IDLE and RUN.
REQ-030 enable_i SHALL be ignored outside IDLE.
REQ-031 All outputs SHALL be registered with zero combinational input-to-output paths.

Reset
REQ-032 On rst=1 at a rising edge: state_o=IDLE, all counters 0, done_o=0, timeout_o=0.
REQ-033 rst SHALL override enable_i, clear_i and a halt hit in the same cycle, including mid-RUN.

Structure
REQ-034 Package soc_mon_pkg SHALL hold the state encoding constants and the default HALT_VALUE and HALT_REG.
REQ-035 SHALL instantiate sub-module sat_counter (parameter W; ports clk, rst, clr, inc, q) once for the cycle counter and NUM_EVT times via generate.

Verification
REQ-036 rst 3 cycles, enable_i 1 cycle, x31 write of 0x3FF on RUN cycle 10 -> DONE, cycle_cnt_o=10, done_o=1, counters then frozen.
REQ-037 evt_i=4'b0101 held for 7 RUN cycles, then halt -> channels 0 and 2 read 7, channels 1 and 3 read 0.
REQ-038 TIMEOUT_CYCLES=20, no halt -> TIMEOUT after edge 20, cycle_cnt_o=20; halt hit on cycle 20 instead -> DONE.
REQ-039 Write of 0x3FF to x0, and write of 0x3FE to x31 -> stays RUN; clear_i in DONE -> IDLE, all counters 0.
REQ-040 CNT_W=4, 20 RUN cycles then halt -> cycle_cnt_o=4'hF; rst asserted mid-RUN -> IDLE, counters 0 on the next edge.
